// File: rtl/instr_encoder.sv
// RV32I instruction encoder: field bundle in, 32-bit machine word out.
// Two register stages with valid/ready on both sides: stage 1 captures the
// request fields, stage 2 registers the encoded word and its range-error flag.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               fmt,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic signed [31:0]       imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_err,
  output logic [CNT_W-1:0]         enc_count
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // True when imm[31:msb] are all copies of one bit, i.e. the value fits a
  // signed field whose sign bit sits at position msb.
  function automatic logic imm_fits(input logic signed [31:0] v,
                                    input int unsigned msb);
    logic signed [31:0] s;
    s = v >>> msb;
    return (s == 32'sd0) || (s == -32'sd1);
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                vld_p1;
  logic                vld_p2;
  logic [2:0]          r_fmt_p1;
  logic [6:0]          r_opcode_p1;
  logic [4:0]          r_rd_p1;
  logic [4:0]          r_rs1_p1;
  logic [4:0]          r_rs2_p1;
  logic [2:0]          r_funct3_p1;
  logic [6:0]          r_funct7_p1;
  logic signed [31:0]  r_imm_p1;
  logic [31:0]         r_instr_p2;
  logic                r_err_p2;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_s1_ready;
  logic                w_s2_ready;
  logic [31:0]         w_instr;
  logic                w_err;

  assign w_s2_ready = !vld_p2 || out_ready;
  assign w_s1_ready = !vld_p1 || w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign out_valid  = vld_p2;
  assign out_instr  = r_instr_p2;
  assign out_err    = r_err_p2;
  assign enc_count  = r_cnt;

  // ---- stage 0 -> 1 : capture request fields ----

  // Stage-1 valid: refilled (or emptied) whenever stage 1 is allowed to move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (w_s1_ready) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage-1 fields: loaded only on an accepted request, held during stalls.
  always_ff @(posedge clk) begin
    if (in_valid && w_s1_ready) begin
      r_fmt_p1    <= fmt;
      r_opcode_p1 <= opcode;
      r_rd_p1     <= rd;
      r_rs1_p1    <= rs1;
      r_rs2_p1    <= rs2;
      r_funct3_p1 <= funct3;
      r_funct7_p1 <= funct7;
      r_imm_p1    <= imm;
    end
  end

  // ---- stage 1 -> 2 : encode and register the word ----

  // Field packing per format; out-of-range immediates still encode their low bits.
  always_comb begin
    w_instr = NOP_WORD;
    w_err   = 1'b1;
    case (r_fmt_p1)
      FMT_I: begin
        w_instr = {r_imm_p1[11:0], r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
        w_err   = !imm_fits(r_imm_p1, 11);
      end
      FMT_S: begin
        w_instr = {r_imm_p1[11:5], r_rs2_p1, r_rs1_p1, r_funct3_p1,
                   r_imm_p1[4:0], r_opcode_p1};
        w_err   = !imm_fits(r_imm_p1, 11);
      end
      FMT_B: begin
        w_instr = {r_imm_p1[12], r_imm_p1[10:5], r_rs2_p1, r_rs1_p1, r_funct3_p1,
                   r_imm_p1[4:1], r_imm_p1[11], r_opcode_p1};
        w_err   = !imm_fits(r_imm_p1, 12) || r_imm_p1[0];
      end
      FMT_U: begin
        w_instr = {r_imm_p1[31:12], r_rd_p1, r_opcode_p1};
        w_err   = (r_imm_p1[11:0] != 12'd0);
      end
      FMT_J: begin
        w_instr = {r_imm_p1[20], r_imm_p1[10:1], r_imm_p1[11], r_imm_p1[19:12],
                   r_rd_p1, r_opcode_p1};
        w_err   = !imm_fits(r_imm_p1, 20) || r_imm_p1[0];
      end
      FMT_R: begin
        w_instr = {r_funct7_p1, r_rs2_p1, r_rs1_p1, r_funct3_p1, r_rd_p1, r_opcode_p1};
        w_err   = 1'b0;
      end
      default: begin
        w_instr = NOP_WORD;
        w_err   = 1'b1;
      end
    endcase
  end

  // Output stage: advances when empty or drained; holds word and flag while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      r_instr_p2 <= 32'd0;
      r_err_p2   <= 1'b0;
    end else if (w_s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        r_instr_p2 <= w_instr;
        r_err_p2   <= w_err;
      end
    end
  end

  // ---- output handshake accounting ----

  // Count delivered words, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (vld_p2 && out_ready) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a driver pushes hand-computed expected words into
// a scoreboard queue on each accepted request; a monitor pops and compares on
// every output handshake.
module tb_instr_encoder;

  localparam int CNT_W = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic signed [31:0] imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic              out_err;
  logic [CNT_W-1:0]  enc_count;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .enc_count(enc_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic bad(input string nm);
    n_tot++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  // The recorded cycle is the one in which valid&&ready held, so a word with
  // no backpressure shows up on out_valid two cycles later.
  task automatic send(input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] ei, input logic ee, input bit lat);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) begin
      e.instr = ei; e.err = ee; e.cyc = cyc - 1; e.lat = lat;
      sb.push_back(e);
    end else begin
      bad("send_accept");
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 80 && !done; n++) begin
      if (sb.size() == 0 && !out_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) bad("drain");
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        bad("unexpected_word");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_err", {31'd0, out_err}, {31'd0, e.err});
        if (e.lat) chk("latency", cyc - e.cyc, 32'd2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_enc_count", {28'd0, enc_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back ALU/store/R words with latency checked
    send(3'b000, 7'b0010011, 5'd15, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4, 32'h00400793, 1'b0, 1'b1);
    send(3'b001, 7'b0100011, 5'd0, 5'd8, 5'd15, 3'b010, 7'd0, -32'sd20, 32'hFEF42623, 1'b0, 1'b1);
    send(3'b101, 7'b0110011, 5'd10, 5'd11, 5'd12, 3'b000, 7'b0100000, 32'd0, 32'h40C58533, 1'b0, 1'b1);
    wait_drain();
    chk("count_after_stream", {28'd0, enc_count}, 32'd3);

    // Reset with two words in flight: both are discarded
    send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 32'h00100093, 1'b0, 1'b0);
    send(3'b000, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 32'h00200113, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_enc_count", {28'd0, enc_count}, 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("postrst_enc_count", {28'd0, enc_count}, 32'd0);

    // Branch encodes: legal, odd offset, out of range
    send(3'b010, 7'b1100011, 5'd0, 5'd11, 5'd0, 3'b000, 7'd0, 32'd12, 32'h00058663, 1'b0, 1'b1);
    send(3'b010, 7'b1100011, 5'd0, 5'd11, 5'd0, 3'b000, 7'd0, 32'd13, 32'h00058663, 1'b1, 1'b1);
    send(3'b010, 7'b1100011, 5'd0, 5'd11, 5'd0, 3'b000, 7'd0, 32'd4096, 32'h80058063, 1'b1, 1'b1);
    wait_drain();
    chk("count_after_branch", {28'd0, enc_count}, 32'd3);

    // Backpressure: two accepts fill the pipe, the output word holds
    out_ready = 1'b0;
    send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 32'h00100093, 1'b0, 1'b0);
    send(3'b000, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 32'h00200113, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_instr", out_instr, 32'h00100093);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'b000, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 32'h00300193, 1'b0, 1'b0);
    wait_drain();
    chk("count_after_bp", {28'd0, enc_count}, 32'd6);

    // Illegal format, misaligned U immediate, J with negative offset
    send(3'b111, 7'd0, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'h00000013, 1'b1, 1'b1);
    send(3'b011, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345001, 32'h123450B7, 1'b1, 1'b1);
    send(3'b100, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2, 32'hFFFFF06F, 1'b0, 1'b1);
    wait_drain();
    chk("count_after_misc", {28'd0, enc_count}, 32'd9);

    // Saturation: 20 more words would wrap a 4-bit counter to 13
    for (int k = 0; k < 20; k++)
      send(3'b101, 7'b0110011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 32'h00000033, 1'b0, 1'b1);
    wait_drain();
    chk("count_saturated", {28'd0, enc_count}, 32'd15);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
